rr_arb4: RTL and testbench

Four-way round-robin arbiter, directly upstream of the 4-to-2 encoder. Collects four request lines and drives a registered, strictly one-hot grant vector that the encoder turns into a 2-bit requester index. The grant is held stable until the consumer acknowledges it, and a timeout revokes a stalled grant. The encoder therefore sees only legal one-hot codes or all-zero.

---
 rtl/rr_arb4_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/rr_arb4.sv | 99 +++++++++
 tb/tb_rr_arb4.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared types and helpers for the four-way round-robin arbiter.
`default_nettype none

package rr_arb4_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [N_REQ-1:0] code;
    code      = '0;
    code[idx] = 1'b1;
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotate-priority picker; the first set request at or after ptr wins.
`default_nettype none

module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             any,
  output logic [1:0]       win_idx
);

  // Walk offsets from lowest to highest priority so the nearest requester overwrites last.
  always_comb begin
    any     = 1'b0;
    win_idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        any     = 1'b1;
        win_idx = ptr + 2'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter with registered one-hot grant, ack handoff
// and a hold timeout that revokes an unacknowledged grant.
`default_nettype none

module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             gnt_valid_q;
  logic             timeout_q;

  logic [1:0]       pick_ptr;
  logic             pick_any;
  logic [1:0]       pick_idx;

  // On an ack the picker already sees the rotated pointer, enabling a same-edge handoff.
  assign pick_ptr = (state_q == GRANT && ack) ? (idx_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q       <= onehot4(pick_idx);
            gnt_valid_q <= 1'b1;
            idx_q       <= pick_idx;
            cnt_q       <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (ack) begin
            ptr_q <= idx_q + 2'd1;
            if (pick_any) begin
              gnt_q       <= onehot4(pick_idx);
              gnt_valid_q <= 1'b1;
              idx_q       <= pick_idx;
              cnt_q       <= '0;
            end else begin
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (cnt_q == CNT_LAST) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            ptr_q       <= idx_q + 2'd1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed stimulus with a behavioural round-robin model checked every cycle.
`default_nettype none

module tb_rr_arb4;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  // Model: owner of the grant (-1 = none), priority start, cycles the grant has been visible.
  int m_owner;
  int m_ptr;
  int m_age;
  bit m_to;

  rr_arb4 #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_age   <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner < 0) begin
        m_owner <= pick(req, m_ptr);
        m_age   <= 1;
      end else if (ack) begin
        m_ptr   <= (m_owner + 1) % 4;
        m_owner <= pick(req, (m_owner + 1) % 4);
        m_age   <= 1;
      end else if (m_age >= TMO) begin
        m_to    <= 1'b1;
        m_ptr   <= (m_owner + 1) % 4;
        m_owner <= -1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !rst) begin
      check("cmp_gnt", gnt, model_gnt());
      check("cmp_valid", {3'b000, gnt_valid}, {3'b000, (m_owner >= 0)});
      check("cmp_timeout", {3'b000, timeout}, {3'b000, m_to});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic a);
    req = r;
    ack = a;
  endtask

  logic [3:0] fair_seq [4];

  initial begin
    fair_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    drive(4'b0000, 1'b0);
    repeat (2) tick();
    check("reset_gnt", gnt, 4'b0000);
    check("reset_valid", {3'b000, gnt_valid}, 4'b0000);
    check("reset_timeout", {3'b000, timeout}, 4'b0000);
    rst   = 1'b0;
    armed = 1'b1;

    // Grant, hold without ack up to the timeout, then one dead cycle.
    drive(4'b1010, 1'b0);
    tick();
    check("A_grant", gnt, 4'b0010);
    check("A_valid", {3'b000, gnt_valid}, 4'b0001);
    repeat (3) begin
      tick();
      check("A_hold", gnt, 4'b0010);
    end
    tick();
    check("A_revoke", gnt, 4'b0000);
    check("A_timeout", {3'b000, timeout}, 4'b0001);
    tick();
    check("A_regrant", gnt, 4'b1000);
    check("A_pulse_end", {3'b000, timeout}, 4'b0000);
    drive(4'b0000, 1'b1);
    tick();
    check("A_release", gnt, 4'b0000);

    // Fairness with ack held high: no zero cycles between grants.
    drive(4'b1111, 1'b0);
    tick();
    check("B_first", gnt, 4'b0001);
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("B_rotate", gnt, fair_seq[i]);
    end
    drive(4'b0000, 1'b1);
    tick();
    check("B_release", gnt, 4'b0000);
    tick();
    check("B_idle_ack", gnt, 4'b0000);

    // Timeout on a lone requester; pointer advances past it.
    drive(4'b0100, 1'b0);
    tick();
    check("C_grant", gnt, 4'b0100);
    repeat (3) tick();
    check("C_hold_last", gnt, 4'b0100);
    tick();
    check("C_revoke", gnt, 4'b0000);
    check("C_timeout", {3'b000, timeout}, 4'b0001);
    check("C_model_ptr", 4'(m_ptr), 4'd3);
    drive(4'b0101, 1'b0);
    tick();
    check("C_next_ptr3", gnt, 4'b0001);
    drive(4'b0000, 1'b1);
    tick();

    // Ack on the would-be timeout cycle wins: normal handoff, no pulse.
    drive(4'b0100, 1'b0);
    tick();
    check("D_grant", gnt, 4'b0100);
    repeat (3) tick();
    drive(4'b0001, 1'b1);
    tick();
    check("D_handoff", gnt, 4'b0001);
    check("D_no_timeout", {3'b000, timeout}, 4'b0000);
    drive(4'b0000, 1'b1);
    tick();

    // Granted request drops; grant held until ack.
    drive(4'b0001, 1'b0);
    tick();
    check("E_grant", gnt, 4'b0001);
    drive(4'b0000, 1'b0);
    repeat (2) begin
      tick();
      check("E_held", gnt, 4'b0001);
    end
    drive(4'b0000, 1'b1);
    tick();
    check("E_clear", gnt, 4'b0000);
    check("E_clear_valid", {3'b000, gnt_valid}, 4'b0000);

    // Asynchronous reset between edges while bit 3 is granted.
    drive(4'b1000, 1'b0);
    tick();
    check("F_grant", gnt, 4'b1000);
    drive(4'b0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("F_async_gnt", gnt, 4'b0000);
    check("F_async_valid", {3'b000, gnt_valid}, 4'b0000);
    tick();
    rst = 1'b0;
    drive(4'b1001, 1'b0);
    tick();
    check("F_after_reset", gnt, 4'b0001);
    drive(4'b0000, 1'b1);
    tick();
    check("F_release", gnt, 4'b0000);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
